ccip_dma_rd_engine: RTL and testbench

//  AFU-side initiator for host-memory reads over CCI-P channel c0: issues a burst of single-line

---
 rtl/ccip_dma_pkg.sv | 20 ++
 rtl/dma_rsp_fifo.sv | 64 ++++++
 rtl/ccip_dma_rd_engine.sv | 154 +++++++++++++++
 tb/tb_ccip_dma_rd_engine.sv | 437 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ccip_dma_pkg.sv
// Shared types and widths for the CCI-P c0 DMA read engine.
package ccip_dma_pkg;

    localparam int CL_ADDR_W = 42;
    localparam int CL_DATA_W = 512;
    localparam int MDATA_W   = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } dma_state_t;

    typedef struct packed {
        logic [MDATA_W-1:0]   mdata;
        logic [CL_DATA_W-1:0] data;
    } dma_rsp_t;

endpackage

// File: rtl/dma_rsp_fifo.sv
// Synchronous show-ahead FIFO holding read responses in arrival order.
module dma_rsp_fifo
    import ccip_dma_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     i_push,
    input  dma_rsp_t i_data,
    input  logic     i_pop,
    output dma_rsp_t o_data,
    output logic     o_full,
    output logic     o_empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    dma_rsp_t         r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_push;
    logic             w_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign o_full  = (r_count == CNT_W'(DEPTH));
    assign o_empty = (r_count == '0);
    // A pop frees the slot in the same cycle, so push on full is accepted alongside a pop.
    assign w_pop   = i_pop && !o_empty;
    assign w_push  = i_push && (!o_full || w_pop);
    assign o_data  = r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= ptr_inc(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CNT_W'(1);
            end else if (!w_push && w_pop) begin
                r_count <= r_count - CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/ccip_dma_rd_engine.sv
// CCI-P c0 read initiator: issues single-line reads for a command and streams the
// returned lines, in arrival order and tagged with their index, to a consumer.
module ccip_dma_rd_engine
    import ccip_dma_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 16,
    parameter int LEN_W           = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_start,
    input  logic [CL_ADDR_W-1:0] i_base_addr,
    input  logic [LEN_W-1:0]     i_num_lines,
    output logic                 o_busy,
    output logic                 o_done,
    output logic                 o_err,
    output logic                 o_c0_tx_valid,
    output logic [CL_ADDR_W-1:0] o_c0_tx_addr,
    output logic [MDATA_W-1:0]   o_c0_tx_mdata,
    input  logic                 i_c0_tx_almfull,
    input  logic                 i_c0_rx_rsp,
    input  logic [MDATA_W-1:0]   i_c0_rx_mdata,
    input  logic [CL_DATA_W-1:0] i_c0_rx_data,
    output logic                 o_out_valid,
    input  logic                 i_out_ready,
    output logic [MDATA_W-1:0]   o_out_idx,
    output logic [CL_DATA_W-1:0] o_out_data,
    output dma_state_t           o_dbg_state
);

    localparam int CRED_W = $clog2(MAX_OUTSTANDING + 1);

    dma_state_t           r_state;
    dma_state_t           w_state_d;
    logic [CL_ADDR_W-1:0] r_base;
    logic [LEN_W-1:0]     r_num;
    logic [LEN_W-1:0]     r_req_cnt;
    logic [LEN_W-1:0]     r_deliv_cnt;
    logic [CRED_W-1:0]    r_credits;
    logic                 r_busy;
    logic                 r_done;
    logic                 r_err;
    logic                 r_tx_valid;
    logic [CL_ADDR_W-1:0] r_tx_addr;
    logic [MDATA_W-1:0]   r_tx_mdata;

    logic                 w_start_ok;
    logic                 w_issue;
    logic                 w_last_req;
    logic                 w_pop;
    logic                 w_rsp_push;
    logic                 w_stray;
    logic                 w_fifo_full;
    logic                 w_fifo_empty;
    dma_rsp_t             w_fifo_in;
    dma_rsp_t             w_fifo_out;

    // Stream handshake: a line transfers on any cycle with o_out_valid && i_out_ready;
    // while valid is high and ready is low, idx/data are held unchanged.
    assign w_start_ok = i_start && (r_state == IDLE);
    assign w_issue    = (r_state == REQ) && !i_c0_tx_almfull &&
                        (r_credits < CRED_W'(MAX_OUTSTANDING));
    assign w_last_req = w_issue && ((r_req_cnt + LEN_W'(1)) == r_num);
    assign w_pop      = o_out_valid && i_out_ready;
    assign w_stray    = i_c0_rx_rsp && (r_credits == '0);
    assign w_rsp_push = i_c0_rx_rsp && (r_credits != '0) && (!w_fifo_full || w_pop);
    assign w_fifo_in  = '{mdata: i_c0_rx_mdata, data: i_c0_rx_data};

    always_comb begin
        w_state_d = r_state;
        case (r_state)
            IDLE:    if (w_start_ok) w_state_d = (i_num_lines == '0) ? DONE : REQ;
            REQ:     if (w_last_req) w_state_d = DRAIN;
            DRAIN:   if (r_deliv_cnt == r_num) w_state_d = DONE;
            DONE:    w_state_d = IDLE;
            default: w_state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_base      <= '0;
            r_num       <= '0;
            r_req_cnt   <= '0;
            r_deliv_cnt <= '0;
            r_credits   <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_tx_valid  <= 1'b0;
            r_tx_addr   <= '0;
            r_tx_mdata  <= '0;
        end else begin
            r_state <= w_state_d;
            r_busy  <= (w_state_d == REQ) || (w_state_d == DRAIN);
            r_done  <= (w_state_d == DONE);

            if (w_start_ok) begin
                r_base      <= i_base_addr;
                r_num       <= i_num_lines;
                r_req_cnt   <= '0;
                r_deliv_cnt <= '0;
            end else begin
                if (w_issue) r_req_cnt <= r_req_cnt + LEN_W'(1);
                if (w_pop)   r_deliv_cnt <= r_deliv_cnt + LEN_W'(1);
            end

            r_tx_valid <= w_issue;
            if (w_issue) begin
                r_tx_addr  <= r_base + CL_ADDR_W'(r_req_cnt);
                r_tx_mdata <= MDATA_W'(r_req_cnt);
            end

            if (w_issue && !w_pop) begin
                r_credits <= r_credits + CRED_W'(1);
            end else if (!w_issue && w_pop) begin
                r_credits <= r_credits - CRED_W'(1);
            end

            // A stray response in the same cycle as a start still leaves the flag set.
            if (w_stray) begin
                r_err <= 1'b1;
            end else if (w_start_ok) begin
                r_err <= 1'b0;
            end
        end
    end

    dma_rsp_fifo #(
        .DEPTH(MAX_OUTSTANDING)
    ) u_rsp_fifo (
        .clk    (clk),
        .rst    (rst),
        .i_push (w_rsp_push),
        .i_data (w_fifo_in),
        .i_pop  (w_pop),
        .o_data (w_fifo_out),
        .o_full (w_fifo_full),
        .o_empty(w_fifo_empty)
    );

    assign o_busy        = r_busy;
    assign o_done        = r_done;
    assign o_err         = r_err;
    assign o_c0_tx_valid = r_tx_valid;
    assign o_c0_tx_addr  = r_tx_addr;
    assign o_c0_tx_mdata = r_tx_mdata;
    assign o_out_valid   = !w_fifo_empty;
    assign o_out_idx     = w_fifo_out.mdata;
    assign o_out_data    = w_fifo_out.data;
    assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_ccip_dma_rd_engine.sv
// Self-checking bench for ccip_dma_rd_engine: host-memory responder plus a line-level model.
module tb_ccip_dma_rd_engine;
    import ccip_dma_pkg::*;

    localparam int MAXO = 16;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 start;
    logic [CL_ADDR_W-1:0] base_addr;
    logic [15:0]          num_lines;
    logic                 busy, done, err;
    logic                 tx_valid;
    logic [CL_ADDR_W-1:0] tx_addr;
    logic [MDATA_W-1:0]   tx_mdata;
    logic                 almfull;
    logic                 rx_rsp;
    logic [MDATA_W-1:0]   rx_mdata;
    logic [CL_DATA_W-1:0] rx_data;
    logic                 out_valid, out_ready;
    logic [MDATA_W-1:0]   out_idx;
    logic [CL_DATA_W-1:0] out_data;
    dma_state_t           dbg_state;

    always #5 clk = ~clk;

    ccip_dma_rd_engine #(.MAX_OUTSTANDING(MAXO), .LEN_W(16)) dut (
        .clk(clk), .rst(rst), .i_start(start), .i_base_addr(base_addr), .i_num_lines(num_lines),
        .o_busy(busy), .o_done(done), .o_err(err),
        .o_c0_tx_valid(tx_valid), .o_c0_tx_addr(tx_addr), .o_c0_tx_mdata(tx_mdata),
        .i_c0_tx_almfull(almfull), .i_c0_rx_rsp(rx_rsp), .i_c0_rx_mdata(rx_mdata),
        .i_c0_rx_data(rx_data), .o_out_valid(out_valid), .i_out_ready(out_ready),
        .o_out_idx(out_idx), .o_out_data(out_data), .o_dbg_state(dbg_state)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [15:0] tag;
        int          due;
    } pend_t;

    logic [CL_ADDR_W-1:0]         obs_addr_q[$];
    logic [15:0]                  obs_mdata_q[$];
    logic [15:0]                  obs_idx_q[$];
    logic [CL_DATA_W-1:0]         obs_data_q[$];
    logic [MDATA_W+CL_DATA_W-1:0] exp_q[$];
    pend_t                        pend_q[$];
    logic [15:0]                  man_q[$];

    int          done_cnt = 0, af_viol = 0, busy_viol = 0, cred_viol = 0, stab_viol = 0;
    int          issued_tot = 0, popped_tot = 0, cyc = 0;
    int          rsp_mode = 0;   // 0 in-order after delay, 1 random order, 2 manual tags
    int          delay = 2;
    bit          expect_accept = 1'b1;
    bit          ready_rand = 1'b0, ready_lvl = 1'b1, af_rand = 1'b0, af_lvl = 1'b0;
    logic [15:0] salt = 16'h0;
    logic        af_seen = 1'b0;
    logic        prev_stall = 1'b0;
    logic [15:0] prev_idx;
    logic [CL_DATA_W-1:0] prev_data;

    function automatic logic [CL_DATA_W-1:0] gen_data(input logic [15:0] tag, input logic [15:0] s);
        logic [CL_DATA_W-1:0] d;
        for (int i = 0; i < 16; i++) d[i*32 +: 32] = {s ^ 16'(i * 16'h1111), tag};
        return d;
    endfunction

    always @(posedge clk) af_seen <= almfull;

    // Host memory model and input pacing, all applied just after the rising edge.
    always @(posedge clk) begin
        int          sel;
        logic [15:0] tag;
        bit          send;
        #1;
        cyc++;
        rx_rsp = 1'b0;
        send   = 1'b0;
        tag    = '0;
        if (!rst) begin
            if (rsp_mode == 2) begin
                if (man_q.size() > 0) begin
                    tag  = man_q.pop_front();
                    send = 1'b1;
                end
            end else if (pend_q.size() > 0) begin
                sel = (rsp_mode == 1) ? int'($urandom_range(0, pend_q.size() - 1)) : 0;
                if (pend_q[sel].due <= cyc) begin
                    tag  = pend_q[sel].tag;
                    send = 1'b1;
                    pend_q.delete(sel);
                end
            end
        end
        if (send) begin
            rx_rsp   = 1'b1;
            rx_mdata = tag;
            rx_data  = gen_data(tag, salt);
            if (expect_accept) exp_q.push_back({tag, gen_data(tag, salt)});
        end
        out_ready = ready_rand ? ($urandom_range(0, 3) != 0) : ready_lvl;
        almfull   = af_rand ? ($urandom_range(0, 3) == 0) : af_lvl;
    end

    // Observer: records requests, deliveries and protocol violations mid-cycle.
    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (tx_valid) begin
                obs_addr_q.push_back(tx_addr);
                obs_mdata_q.push_back(tx_mdata);
                pend_q.push_back('{tag: tx_mdata, due: cyc + delay});
                if (af_seen) af_viol++;
                issued_tot++;
            end
            if (out_valid && out_ready) begin
                obs_idx_q.push_back(out_idx);
                obs_data_q.push_back(out_data);
                popped_tot++;
            end
            if (issued_tot - popped_tot > MAXO) cred_viol++;
            if (prev_stall && (!out_valid || out_idx !== prev_idx || out_data !== prev_data)) stab_viol++;
            prev_stall = out_valid && !out_ready;
            prev_idx   = out_idx;
            prev_data  = out_data;
            if (done) begin
                done_cnt++;
                if (busy) busy_viol++;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_model();
        obs_addr_q.delete(); obs_mdata_q.delete(); obs_idx_q.delete(); obs_data_q.delete();
        exp_q.delete(); pend_q.delete(); man_q.delete();
        salt = 16'($urandom);
    endtask

    task automatic start_cmd(input logic [CL_ADDR_W-1:0] b, input logic [15:0] n);
        base_addr = b;
        num_lines = n;
        start     = 1'b1;
        tick(1);
        start     = 1'b0;
    endtask

    task automatic wait_done(input int d0, input int budget, input string nm);
        int t = 0;
        while (done_cnt == d0 && t < budget) begin
            tick(1);
            t++;
        end
        checks++;
        if (done_cnt == d0) begin
            errors++;
            $display("FAIL %s done_timeout got no done within %0d cycles", nm, budget);
        end
    endtask

    task automatic wait_reqs(input int n, input int budget, input string nm);
        int t = 0;
        while (obs_addr_q.size() < n && t < budget) begin
            tick(1);
            t++;
        end
        checks++;
        if (obs_addr_q.size() < n) begin
            errors++;
            $display("FAIL %s req_wait got %0d requests want %0d", nm, obs_addr_q.size(), n);
        end
    endtask

    task automatic test_reset();
        checks++;
        if ({busy, done, err, tx_valid, out_valid} !== 5'b0 || tx_addr !== '0 ||
            tx_mdata !== '0 || dbg_state !== IDLE) begin
            errors++;
            $display("FAIL reset_values got b%0b d%0b e%0b tv%0b ov%0b addr %h md %h st %0d want all 0",
                     busy, done, err, tx_valid, out_valid, tx_addr, tx_mdata, dbg_state);
        end
    endtask

    task automatic test_basic();
        logic [CL_ADDR_W-1:0] b = 42'h1000;
        int d0 = done_cnt;
        clear_model();
        rsp_mode = 0; delay = 2; ready_rand = 0; ready_lvl = 1;
        start_cmd(b, 16'd4);
        wait_done(d0, 200, "basic");
        tick(3);
        checks++;
        if (obs_addr_q.size() != 4 || obs_idx_q.size() != 4) begin
            errors++;
            $display("FAIL basic_counts got req %0d out %0d want 4 4", obs_addr_q.size(), obs_idx_q.size());
        end
        for (int k = 0; k < 4 && k < obs_addr_q.size(); k++) begin
            checks++;
            if (obs_addr_q[k] !== b + 42'(k) || obs_mdata_q[k] !== 16'(k)) begin
                errors++;
                $display("FAIL basic_req%0d got %h/%0d want %h/%0d", k, obs_addr_q[k], obs_mdata_q[k], b + 42'(k), k);
            end
        end
        for (int k = 0; k < obs_idx_q.size() && exp_q.size() > 0; k++) begin
            checks++;
            if ({obs_idx_q[k], obs_data_q[k]} !== exp_q[0] || obs_idx_q[k] !== 16'(k)) begin
                errors++;
                $display("FAIL basic_out%0d got idx %0d want idx %0d", k, obs_idx_q[k], k);
            end
            void'(exp_q.pop_front());
        end
        checks++;
        if (done_cnt - d0 != 1 || err !== 1'b0 || busy_viol != 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL basic_status got done %0d err %0b busy_viol %0d busy %0b want 1 0 0 0",
                     done_cnt - d0, err, busy_viol, busy);
        end
    endtask

    task automatic test_credit_stall();
        logic [CL_ADDR_W-1:0] b = 42'h3FF_FFFF_FFF0;   // crosses the 2^42 wrap
        int d0 = done_cnt;
        clear_model();
        rsp_mode = 1; delay = int'($urandom_range(1, 6)); ready_rand = 0; ready_lvl = 0;
        start_cmd(b, 16'd40);
        tick(60);
        checks++;
        if (obs_addr_q.size() != MAXO || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL credit_stall got %0d requests out_valid %0b want %0d 1", obs_addr_q.size(), out_valid, MAXO);
        end
        ready_rand = 1; af_rand = 1;
        wait_done(d0, 3000, "credit");
        ready_rand = 0; ready_lvl = 1; af_rand = 0;
        tick(3);
        checks++;
        if (obs_addr_q.size() != 40 || obs_idx_q.size() != 40 || done_cnt - d0 != 1) begin
            errors++;
            $display("FAIL credit_counts got req %0d out %0d done %0d want 40 40 1",
                     obs_addr_q.size(), obs_idx_q.size(), done_cnt - d0);
        end
        for (int k = 0; k < obs_addr_q.size(); k++) begin
            checks++;
            if (obs_addr_q[k] !== b + 42'(k) || obs_mdata_q[k] !== 16'(k)) begin
                errors++;
                $display("FAIL credit_req%0d got %h/%0d want %h/%0d", k, obs_addr_q[k], obs_mdata_q[k], b + 42'(k), k);
            end
        end
        for (int k = 0; k < obs_idx_q.size() && exp_q.size() > 0; k++) begin
            checks++;
            if ({obs_idx_q[k], obs_data_q[k]} !== exp_q[0]) begin
                errors++;
                $display("FAIL credit_out%0d got idx %0d want idx %0d", k, obs_idx_q[k], exp_q[0][527:512]);
            end
            void'(exp_q.pop_front());
        end
        checks++;
        if (cred_viol != 0 || stab_viol != 0 || af_viol != 0) begin
            errors++;
            $display("FAIL credit_protocol got cred %0d stab %0d af %0d want 0 0 0", cred_viol, stab_viol, af_viol);
        end
    endtask

    task automatic test_almfull();
        logic [CL_ADDR_W-1:0] b = 42'($urandom);
        int d0 = done_cnt;
        int n1;
        clear_model();
        rsp_mode = 0; delay = 2; ready_lvl = 1;
        start_cmd(b, 16'd30);
        wait_reqs(5, 100, "almfull");
        af_lvl = 1;
        tick(2);
        n1 = obs_addr_q.size();
        tick(8);
        checks++;
        if (obs_addr_q.size() != n1 || af_viol != 0) begin
            errors++;
            $display("FAIL almfull_hold got %0d new requests af_viol %0d want 0 0", obs_addr_q.size() - n1, af_viol);
        end
        af_lvl = 0;
        tick(3);
        checks++;
        if (obs_addr_q.size() <= n1) begin
            errors++;
            $display("FAIL almfull_resume got %0d new requests want >0", obs_addr_q.size() - n1);
        end
        wait_done(d0, 300, "almfull");
        tick(3);
        checks++;
        if (obs_addr_q.size() != 30 || obs_idx_q.size() != 30 || exp_q.size() != 30) begin
            errors++;
            $display("FAIL almfull_counts got req %0d out %0d exp %0d want 30", obs_addr_q.size(), obs_idx_q.size(), exp_q.size());
        end
        for (int k = 0; k < obs_addr_q.size() && k < exp_q.size() && k < obs_idx_q.size(); k++) begin
            checks++;
            if (obs_addr_q[k] !== b + 42'(k) || {obs_idx_q[k], obs_data_q[k]} !== exp_q[k]) begin
                errors++;
                $display("FAIL almfull_line%0d got addr %h idx %0d want addr %h idx %0d",
                         k, obs_addr_q[k], obs_idx_q[k], b + 42'(k), exp_q[k][527:512]);
            end
        end
    endtask

    task automatic test_reverse();
        logic [CL_ADDR_W-1:0] b = 42'({$urandom, $urandom});
        int d0 = done_cnt;
        clear_model();
        rsp_mode = 2; ready_rand = 1;
        start_cmd(b, 16'd4);
        wait_reqs(4, 50, "reverse");
        tick(2);
        man_q = '{16'd3, 16'd2, 16'd1, 16'd0};
        wait_done(d0, 200, "reverse");
        ready_rand = 0; ready_lvl = 1;
        tick(3);
        checks++;
        if (obs_idx_q.size() != 4) begin
            errors++;
            $display("FAIL reverse_count got %0d want 4", obs_idx_q.size());
        end
        for (int k = 0; k < obs_idx_q.size() && k < 4; k++) begin
            checks++;
            if (obs_idx_q[k] !== 16'(3 - k) || obs_data_q[k] !== gen_data(16'(3 - k), salt) ||
                obs_addr_q[k] !== b + 42'(k)) begin
                errors++;
                $display("FAIL reverse_out%0d got idx %0d want idx %0d", k, obs_idx_q[k], 3 - k);
            end
        end
    endtask

    task automatic test_zero_and_busy_start();
        logic [CL_ADDR_W-1:0] b1 = 42'($urandom);
        int d0 = done_cnt;
        clear_model();
        rsp_mode = 0; delay = 2; ready_lvl = 1;
        start_cmd(42'($urandom), 16'd0);
        checks++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL zero_len_done got done %0b busy %0b want 1 0", done, busy);
        end
        tick(1);
        checks++;
        if (done !== 1'b0 || done_cnt - d0 != 1 || obs_addr_q.size() != 0) begin
            errors++;
            $display("FAIL zero_len_after got done %0b pulses %0d reqs %0d want 0 1 0", done, done_cnt - d0, obs_addr_q.size());
        end
        d0 = done_cnt;
        start_cmd(b1, 16'd6);
        tick(1);
        start_cmd(b1 + 42'h500, 16'd3);
        wait_done(d0, 200, "busy_start");
        tick(5);
        checks++;
        if (obs_addr_q.size() != 6 || obs_idx_q.size() != 6 || done_cnt - d0 != 1 || busy_viol != 0) begin
            errors++;
            $display("FAIL busy_start_counts got req %0d out %0d done %0d want 6 6 1",
                     obs_addr_q.size(), obs_idx_q.size(), done_cnt - d0);
        end
        for (int k = 0; k < obs_addr_q.size(); k++) begin
            checks++;
            if (obs_addr_q[k] !== b1 + 42'(k) || obs_mdata_q[k] !== 16'(k)) begin
                errors++;
                $display("FAIL busy_start_req%0d got %h want %h", k, obs_addr_q[k], b1 + 42'(k));
            end
        end
    endtask

    task automatic test_mid_reset();
        int t = 0;
        int d0;
        clear_model();
        rsp_mode = 2; ready_lvl = 0;
        start_cmd(42'($urandom), 16'd8);
        while (obs_addr_q.size() < 5 && t < 50) begin
            @(negedge clk);
            #1;
            t++;
        end
        rst = 1'b1;
        #1;
        checks++;
        if (obs_addr_q.size() != 5 || {busy, done, err, tx_valid, out_valid} !== 5'b0 ||
            tx_addr !== '0 || tx_mdata !== '0 || dbg_state !== IDLE) begin
            errors++;
            $display("FAIL mid_reset_values got reqs %0d b%0b d%0b e%0b tv%0b ov%0b want 5 and all 0",
                     obs_addr_q.size(), busy, done, err, tx_valid, out_valid);
        end
        tick(2);
        clear_model();
        expect_accept = 0; ready_lvl = 1;
        d0 = done_cnt;
        rst = 1'b0;
        man_q = '{16'd0, 16'd1, 16'd2, 16'd3, 16'd4};
        tick(10);
        checks++;
        if (err !== 1'b1 || out_valid !== 1'b0 || obs_idx_q.size() != 0 || obs_addr_q.size() != 0 ||
            busy !== 1'b0 || done_cnt != d0) begin
            errors++;
            $display("FAIL mid_reset_stray got err %0b ov %0b outs %0d reqs %0d busy %0b want 1 0 0 0 0",
                     err, out_valid, obs_idx_q.size(), obs_addr_q.size(), busy);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start = 1'b0; base_addr = '0; num_lines = '0;
        almfull = 1'b0; rx_rsp = 1'b0; rx_mdata = '0; rx_data = '0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        rst = 1'b0;
        tick(2);
        test_basic();
        test_credit_stall();
        test_almfull();
        test_reverse();
        test_zero_and_busy_start();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
